regwb_arbiter: RTL and testbench

REGWB_ARBITER -- requirements
Module: regwb_arbiter

---
 rtl/regwb_pkg.sv | 20 ++
 rtl/regwb_arbiter_if.sv | 37 +++
 rtl/regwb_fifo2.sv | 73 +++++++
 rtl/regwb_arbiter.sv | 108 ++++++++++
 tb/tb_regwb_arbiter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/regwb_pkg.sv
// rtl/regwb_pkg.sv - shared constants and types for the register writeback arbiter
package regwb_pkg;

  localparam int AW_DEF         = 6;
  localparam int DW_DEF         = 32;
  localparam int STARVE_MAX_DEF = 3;
  localparam int FIFO_DEPTH     = 2;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } regwb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_e;

endpackage

// File: rtl/regwb_arbiter_if.sv
// rtl/regwb_arbiter_if.sv - writeback request ports and register file write port
interface regwb_arbiter_if
  import regwb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;

  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;

  logic          regwe;
  logic [AW-1:0] Rw;
  logic [DW-1:0] Din;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready,
    input  regwe, Rw, Din
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready,
    output regwe, Rw, Din
  );

endinterface

// File: rtl/regwb_fifo2.sv
// rtl/regwb_fifo2.sv - two-entry queue for port B writebacks
// Exposes every slot's address and valid bit so the arbiter can detect write-after-write hazards.
module regwb_fifo2
  import regwb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [AW-1:0]         push_addr,
  input  logic [DW-1:0]         push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [AW-1:0]         head_addr,
  output logic [DW-1:0]         head_data,
  output logic [AW-1:0]         ent_addr [FIFO_DEPTH],
  output logic [FIFO_DEPTH-1:0] ent_valid
);

  logic [AW-1:0] addr_q [FIFO_DEPTH];
  logic [DW-1:0] data_q [FIFO_DEPTH];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;
  logic          do_push;
  logic          do_pop;

  // full is registered state, so a push is refused on a full queue even if it pops this edge
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        addr_q[wr_ptr] <= push_addr;
        data_q[wr_ptr] <= push_data;
        wr_ptr         <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign ent_addr  = addr_q;

  always_comb begin
    ent_valid          = '0;
    ent_valid[rd_ptr]  = !empty;
    ent_valid[~rd_ptr] = full;
  end

endmodule

// File: rtl/regwb_arbiter.sv
// rtl/regwb_arbiter.sv - arbitrates ALU (A) and queued load (B) writebacks onto one register file port
// A wins by default; B is forced after STARVE_MAX denied cycles and A yields on a pending same-address write.
module regwb_arbiter
  import regwb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  regwb_arbiter_if.slave bus
);

  localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [AW-1:0]         head_addr;
  logic [DW-1:0]         head_data;
  logic [AW-1:0]         ent_addr [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_valid;
  logic [1:0]            starve_cnt;
  logic                  armed;
  logic                  a_blocked;
  grant_e                gnt;

  regwb_fifo2 #(
    .AW (AW),
    .DW (DW)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_addr (bus.b_addr),
    .push_data (bus.b_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_addr (head_addr),
    .head_data (head_data),
    .ent_addr  (ent_addr),
    .ent_valid (ent_valid)
  );

  always_comb begin
    a_blocked = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == bus.a_addr)) begin
        a_blocked = 1'b1;
      end
    end
  end

  // armed stays low for the first edge after reset so nothing commits on it
  always_comb begin
    gnt = GNT_NONE;
    if (armed) begin
      if (!fifo_empty && (starve_cnt == STARVE_LIM)) begin
        gnt = GNT_B;
      end else if (bus.a_valid && !a_blocked) begin
        gnt = GNT_A;
      end else if (!fifo_empty) begin
        gnt = GNT_B;
      end
    end
  end

  assign bus.a_ready = (gnt == GNT_A);
  assign bus.b_ready = !fifo_full;
  assign push        = bus.b_valid && !fifo_full;
  assign pop         = (gnt == GNT_B);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed      <= 1'b0;
      starve_cnt <= 2'd0;
      bus.regwe  <= 1'b0;
      bus.Rw     <= '0;
      bus.Din    <= '0;
    end else begin
      armed <= 1'b1;
      if (fifo_empty || (gnt == GNT_B)) begin
        starve_cnt <= 2'd0;
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 2'd1;
      end
      bus.regwe <= (gnt != GNT_NONE);
      case (gnt)
        GNT_A: begin
          bus.Rw  <= bus.a_addr;
          bus.Din <= bus.a_data;
        end
        GNT_B: begin
          bus.Rw  <= head_addr;
          bus.Din <= head_data;
        end
        default: begin
          bus.Rw  <= bus.Rw;
          bus.Din <= bus.Din;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regwb_arbiter.sv
// tb/tb_regwb_arbiter.sv - directed self-checking bench for regwb_arbiter
module tb_regwb_arbiter;
  import regwb_pkg::*;

  logic clk;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  regwb_arbiter_if #(.AW(AW_DEF), .DW(DW_DEF)) bus ();

  regwb_arbiter #(
    .AW         (AW_DEF),
    .DW         (DW_DEF),
    .STARVE_MAX (STARVE_MAX_DEF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic regwb_entry_t ent(input logic [5:0] a, input logic [31:0] d);
    return {a, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step_in(input logic av, input logic [5:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [5:0] ba, input logic [31:0] bd);
    @(negedge clk);
    bus.a_valid = av;
    bus.a_addr  = aa;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_addr  = ba;
    bus.b_data  = bd;
    #1;
  endtask

  task automatic post(input string tag, input logic we, input regwb_entry_t e);
    @(posedge clk);
    #1;
    chk({tag, "_we"}, 32'(bus.regwe), 32'(we));
    chk({tag, "_rw"}, 32'(bus.Rw), 32'(e.addr));
    chk({tag, "_din"}, bus.Din, e.data);
  endtask

  task automatic rdy(input string tag, input logic ar, input logic br);
    chk({tag, "_a_ready"}, 32'(bus.a_ready), 32'(ar));
    chk({tag, "_b_ready"}, 32'(bus.b_ready), 32'(br));
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.a_valid = 1'b1;
    bus.a_addr  = 6'd5;
    bus.a_data  = 32'hDEADBEEF;
    bus.b_valid = 1'b0;
    bus.b_addr  = 6'd0;
    bus.b_data  = 32'd0;

    // reset values, with a request already pending
    repeat (3) @(negedge clk);
    #1;
    chk("rst_regwe", 32'(bus.regwe), 32'd0);
    chk("rst_rw", 32'(bus.Rw), 32'd0);
    chk("rst_din", bus.Din, 32'd0);
    rdy("rst", 1'b0, 1'b1);

    @(negedge clk);
    reset_n = 1'b1;
    #1;
    rdy("rel", 1'b0, 1'b1);
    post("rel_first_edge", 1'b0, ent(6'd0, 32'd0));

    // A only
    step_in(1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0, 32'd0);
    rdy("a_only", 1'b1, 1'b1);
    post("a_only", 1'b1, ent(6'd5, 32'hDEADBEEF));
    step_in(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    post("a_drop", 1'b0, ent(6'd5, 32'hDEADBEEF));

    // starvation: B forced on the fourth cycle after its push
    step_in(1'b1, 6'd1, 32'h101, 1'b1, 6'd7, 32'h77);
    rdy("st_push", 1'b1, 1'b1);
    post("st_c0", 1'b1, ent(6'd1, 32'h101));
    for (int k = 2; k <= 4; k++) begin
      step_in(1'b1, 6'(k), 32'h100 + 32'(k), 1'b0, 6'd0, 32'd0);
      rdy("st_a", 1'b1, 1'b1);
      post("st_a", 1'b1, ent(6'(k), 32'h100 + 32'(k)));
    end
    step_in(1'b1, 6'd5, 32'h105, 1'b0, 6'd0, 32'd0);
    rdy("st_forced", 1'b0, 1'b1);
    post("st_b", 1'b1, ent(6'd7, 32'h77));
    step_in(1'b1, 6'd5, 32'h105, 1'b0, 6'd0, 32'd0);
    rdy("st_after", 1'b1, 1'b1);
    post("st_a5", 1'b1, ent(6'd5, 32'h105));

    // ordering hazard on addr 10, and no B bypass
    step_in(1'b0, 6'd0, 32'd0, 1'b1, 6'd10, 32'h1);
    rdy("hz_push", 1'b0, 1'b1);
    post("hz_no_bypass", 1'b0, ent(6'd5, 32'h105));
    step_in(1'b1, 6'd10, 32'h2, 1'b0, 6'd0, 32'd0);
    rdy("hz_block", 1'b0, 1'b1);
    post("hz_b", 1'b1, ent(6'd10, 32'h1));
    step_in(1'b1, 6'd10, 32'h2, 1'b0, 6'd0, 32'd0);
    rdy("hz_unblock", 1'b1, 1'b1);
    post("hz_a", 1'b1, ent(6'd10, 32'h2));

    // full FIFO with A saturating; third B request held until a pop
    step_in(1'b1, 6'd20, 32'h20, 1'b1, 6'd30, 32'h30);
    rdy("fl_e0", 1'b1, 1'b1);
    post("fl_e0", 1'b1, ent(6'd20, 32'h20));
    step_in(1'b1, 6'd21, 32'h21, 1'b1, 6'd31, 32'h31);
    rdy("fl_e1", 1'b1, 1'b1);
    post("fl_e1", 1'b1, ent(6'd21, 32'h21));
    step_in(1'b1, 6'd22, 32'h22, 1'b1, 6'd32, 32'h32);
    rdy("fl_e2", 1'b1, 1'b0);
    post("fl_e2", 1'b1, ent(6'd22, 32'h22));
    step_in(1'b1, 6'd23, 32'h23, 1'b1, 6'd32, 32'h32);
    rdy("fl_e3", 1'b1, 1'b0);
    post("fl_e3", 1'b1, ent(6'd23, 32'h23));
    step_in(1'b1, 6'd24, 32'h24, 1'b1, 6'd32, 32'h32);
    rdy("fl_e4", 1'b0, 1'b0);
    post("fl_e4", 1'b1, ent(6'd30, 32'h30));
    step_in(1'b1, 6'd24, 32'h24, 1'b1, 6'd32, 32'h32);
    rdy("fl_e5", 1'b1, 1'b1);
    post("fl_e5", 1'b1, ent(6'd24, 32'h24));
    step_in(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    rdy("fl_e6", 1'b0, 1'b0);
    post("fl_e6", 1'b1, ent(6'd31, 32'h31));
    step_in(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    rdy("fl_e7", 1'b0, 1'b1);
    post("fl_e7", 1'b1, ent(6'd32, 32'h32));
    post("fl_drain", 1'b0, ent(6'd32, 32'h32));

    // reset mid-stream with two entries queued
    step_in(1'b1, 6'd41, 32'h41, 1'b1, 6'd40, 32'h40);
    post("rr_e0", 1'b1, ent(6'd41, 32'h41));
    step_in(1'b1, 6'd43, 32'h43, 1'b1, 6'd42, 32'h42);
    rdy("rr_e1", 1'b1, 1'b1);
    post("rr_e1", 1'b1, ent(6'd43, 32'h43));
    step_in(1'b1, 6'd44, 32'h44, 1'b0, 6'd0, 32'd0);
    rdy("rr_full", 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("rr_async_regwe", 32'(bus.regwe), 32'd0);
    chk("rr_async_rw", 32'(bus.Rw), 32'd0);
    rdy("rr_async", 1'b0, 1'b1);
    step_in(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      post("rr_discard", 1'b0, ent(6'd0, 32'd0));
    end

    // idle holds the last write
    step_in(1'b1, 6'd21, 32'hCAFE, 1'b0, 6'd0, 32'd0);
    post("id_set", 1'b1, ent(6'd21, 32'hCAFE));
    step_in(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    for (int k = 0; k < 10; k++) begin
      post("idle", 1'b0, ent(6'd21, 32'hCAFE));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
